// File: rtl/beat_timing_gen.sv
// Beat/phase timing generator for the hardwired controller.
// Emits one-hot W beats and the T3 sampling pulse.
module beat_timing_gen #(
  parameter int TW    = 3,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             QD,
  input  logic             DP,
  input  logic             SHORT,
  input  logic             LONG,
  input  logic             STOP,
  output logic [2:0]       W_clk,
  output logic             T_clk_3,
  output logic             RUNNING,
  output logic [CNT_W-1:0] BEATS
);

  localparam int PW = $clog2(TW);
  localparam logic [PW-1:0] LAST = PW'(TW - 1);

  localparam logic [2:0] W1 = 3'b001;
  localparam logic [2:0] W2 = 3'b010;
  localparam logic [2:0] W3 = 3'b100;

  logic qd_s1;
  logic qd_s2;
  logic qd_s3;
  logic qd_edge;

  logic [PW-1:0]    phase;
  logic [PW-1:0]    phase_nx;
  logic             running_nx;
  logic             t3_nx;
  logic [2:0]       w_nx;
  logic [2:0]       w_sel;
  logic [CNT_W-1:0] beats_nx;
  logic             beat_end;

  // QD is an async button: two sync flops, one for the edge
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      qd_s1   <= 1'b0;
      qd_s2   <= 1'b0;
      qd_s3   <= 1'b0;
      qd_edge <= 1'b0;
    end else begin
      qd_s1   <= QD;
      qd_s2   <= qd_s1;
      qd_s3   <= qd_s2;
      qd_edge <= qd_s2 & ~qd_s3;
    end
  end

  // Non-one-hot beats fall into default and recover to W1
  always_comb begin
    w_sel = W1;
    case (W_clk)
      W1:      w_sel = SHORT ? W1 : W2;
      W2:      w_sel = LONG ? W3 : W1;
      W3:      w_sel = W1;
      default: w_sel = W1;
    endcase
  end

  always_comb begin
    beat_end   = RUNNING && (phase == LAST);
    phase_nx   = phase;
    running_nx = RUNNING;
    w_nx       = W_clk;
    beats_nx   = BEATS;
    if (!RUNNING) begin
      phase_nx = '0;
      if (qd_edge) begin
        running_nx = 1'b1;
      end
    end else if (beat_end) begin
      phase_nx   = '0;
      beats_nx   = BEATS + 1'b1;
      w_nx       = w_sel;
      running_nx = !(STOP || DP);
    end else begin
      phase_nx = phase + 1'b1;
    end
    t3_nx = running_nx && (phase_nx == LAST);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      phase   <= '0;
      RUNNING <= 1'b0;
      W_clk   <= W1;
      T_clk_3 <= 1'b0;
      BEATS   <= '0;
    end else begin
      phase   <= phase_nx;
      RUNNING <= running_nx;
      W_clk   <= w_nx;
      T_clk_3 <= t3_nx;
      BEATS   <= beats_nx;
    end
  end

endmodule

// File: tb/tb_beat_timing_gen.sv
// Directed bench for beat_timing_gen.
// Second instance with CNT_W=4 covers counter wrap.
module tb_beat_timing_gen;

  logic        CLK;
  logic        CLR;
  logic        QD;
  logic        DP;
  logic        SHORT;
  logic        LONG;
  logic        STOP;
  logic [2:0]  W_clk;
  logic        T_clk_3;
  logic        RUNNING;
  logic [15:0] BEATS;
  logic [2:0]  w4;
  logic        t3_4;
  logic        run4;
  logic [3:0]  beats4;

  int pass_cnt = 0;
  int total_cnt = 0;

  beat_timing_gen #(.TW(3), .CNT_W(16)) dut (
    .CLK(CLK), .CLR(CLR), .QD(QD), .DP(DP),
    .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
    .W_clk(W_clk), .T_clk_3(T_clk_3),
    .RUNNING(RUNNING), .BEATS(BEATS)
  );

  beat_timing_gen #(.TW(3), .CNT_W(4)) dut_w (
    .CLK(CLK), .CLR(CLR), .QD(QD), .DP(DP),
    .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
    .W_clk(w4), .T_clk_3(t3_4),
    .RUNNING(run4), .BEATS(beats4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CLR = 1'b0;
    QD = 1'b0; DP = 1'b0;
    SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0;
    tick();
    CLR = 1'b1;
    tick();
  endtask

  // QD held two cycles; RUNNING is set on the 4th edge
  task automatic press_qd();
    QD = 1'b1;
    tick();
    tick();
    QD = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    CLR = 1'b0;
    QD = 1'b0; DP = 1'b0;
    SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0;
    tick();
    total_cnt++;
    if (W_clk !== 3'b001)
      $display("FAIL reset_w got %b want 001", W_clk);
    else pass_cnt++;
    total_cnt++;
    if (T_clk_3 !== 1'b0)
      $display("FAIL reset_t3 got %b want 0", T_clk_3);
    else pass_cnt++;
    total_cnt++;
    if (RUNNING !== 1'b0)
      $display("FAIL reset_run got %b want 0", RUNNING);
    else pass_cnt++;
    total_cnt++;
    if (BEATS !== 16'd0)
      $display("FAIL reset_beats got %0d want 0", BEATS);
    else pass_cnt++;
    CLR = 1'b1;
    tick();
  endtask

  task automatic test_start();
    logic [2:0] ew;
    do_reset();
    QD = 1'b1;
    tick();
    tick();
    QD = 1'b0;
    tick();
    total_cnt++;
    if (RUNNING !== 1'b0)
      $display("FAIL start_early got %b want 0", RUNNING);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (RUNNING !== 1'b1)
      $display("FAIL start_run got %b want 1", RUNNING);
    else pass_cnt++;
    total_cnt++;
    if (T_clk_3 !== 1'b0)
      $display("FAIL start_t3 got %b want 0", T_clk_3);
    else pass_cnt++;
    for (int i = 1; i <= 12; i++) begin
      tick();
      ew = ((i / 3) % 2 == 0) ? 3'b001 : 3'b010;
      total_cnt++;
      if (T_clk_3 !== (i % 3 == 2))
        $display("FAIL start_t3_%0d got %b want %b",
                 i, T_clk_3, (i % 3 == 2));
      else pass_cnt++;
      total_cnt++;
      if (W_clk !== ew)
        $display("FAIL start_w_%0d got %b want %b", i, W_clk, ew);
      else pass_cnt++;
    end
    total_cnt++;
    if (BEATS !== 16'd4)
      $display("FAIL start_beats got %0d want 4", BEATS);
    else pass_cnt++;
  endtask

  task automatic test_long();
    logic [2:0] ew [0:5];
    ew = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    do_reset();
    LONG = 1'b1;
    press_qd();
    for (int b = 0; b < 6; b++) begin
      total_cnt++;
      if (W_clk !== ew[b])
        $display("FAIL long_w_%0d got %b want %b", b, W_clk, ew[b]);
      else pass_cnt++;
      total_cnt++;
      if (BEATS !== 16'(b))
        $display("FAIL long_beats_%0d got %0d want %0d", b, BEATS, b);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (T_clk_3 !== 1'b1)
        $display("FAIL long_t3_%0d got %b want 1", b, T_clk_3);
      else pass_cnt++;
      tick();
    end
    LONG = 1'b0;
  endtask

  task automatic test_short();
    do_reset();
    SHORT = 1'b1;
    press_qd();
    for (int b = 0; b < 8; b++) begin
      if (b == 4) LONG = 1'b1;
      tick();
      tick();
      tick();
      total_cnt++;
      if (W_clk !== 3'b001)
        $display("FAIL short_w_%0d got %b want 001", b, W_clk);
      else pass_cnt++;
    end
    total_cnt++;
    if (BEATS !== 16'd8)
      $display("FAIL short_beats got %0d want 8", BEATS);
    else pass_cnt++;
    SHORT = 1'b0;
    LONG = 1'b0;
  endtask

  task automatic test_stop();
    do_reset();
    press_qd();
    // QD while running: its edge lands mid-W2 and must be dropped
    QD = 1'b1;
    tick();
    tick();
    QD = 1'b0;
    tick();
    total_cnt++;
    if (W_clk !== 3'b010)
      $display("FAIL stop_w2 got %b want 010", W_clk);
    else pass_cnt++;
    STOP = 1'b1;
    tick();
    tick();
    tick();
    STOP = 1'b0;
    total_cnt++;
    if (RUNNING !== 1'b0)
      $display("FAIL stop_run got %b want 0", RUNNING);
    else pass_cnt++;
    total_cnt++;
    if (BEATS !== 16'd2)
      $display("FAIL stop_beats got %0d want 2", BEATS);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      tick();
      total_cnt++;
      if (W_clk !== 3'b001 || T_clk_3 !== 1'b0 || RUNNING !== 1'b0)
        $display("FAIL stop_hold_%0d got w=%b t3=%b run=%b want 001/0/0",
                 i, W_clk, T_clk_3, RUNNING);
      else pass_cnt++;
    end
    press_qd();
    total_cnt++;
    if (RUNNING !== 1'b1 || W_clk !== 3'b001)
      $display("FAIL stop_resume got run=%b w=%b want 1/001",
               RUNNING, W_clk);
    else pass_cnt++;
    tick();
    tick();
    tick();
    total_cnt++;
    if (W_clk !== 3'b010 || BEATS !== 16'd3)
      $display("FAIL stop_next got w=%b beats=%0d want 010/3",
               W_clk, BEATS);
    else pass_cnt++;
  endtask

  task automatic test_single_step();
    int t3_seen;
    do_reset();
    DP = 1'b1;
    for (int s = 0; s < 2; s++) begin
      press_qd();
      t3_seen = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (T_clk_3 === 1'b1) t3_seen++;
      end
      total_cnt++;
      if (t3_seen != 1)
        $display("FAIL step_t3_%0d got %0d pulses want 1", s, t3_seen);
      else pass_cnt++;
      total_cnt++;
      if (RUNNING !== 1'b0 || BEATS !== 16'(s + 1))
        $display("FAIL step_end_%0d got run=%b beats=%0d want 0/%0d",
                 s, RUNNING, BEATS, s + 1);
      else pass_cnt++;
      total_cnt++;
      if (W_clk !== (s == 0 ? 3'b010 : 3'b001))
        $display("FAIL step_w_%0d got %b want %b",
                 s, W_clk, (s == 0 ? 3'b010 : 3'b001));
      else pass_cnt++;
    end
    DP = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    LONG = 1'b1;
    press_qd();
    repeat (7) tick();
    total_cnt++;
    if (W_clk !== 3'b100)
      $display("FAIL areset_pre got %b want 100", W_clk);
    else pass_cnt++;
    #2;
    CLR = 1'b0;
    #1;
    total_cnt++;
    if (W_clk !== 3'b001 || T_clk_3 !== 1'b0)
      $display("FAIL areset_w_t3 got w=%b t3=%b want 001/0",
               W_clk, T_clk_3);
    else pass_cnt++;
    total_cnt++;
    if (RUNNING !== 1'b0 || BEATS !== 16'd0)
      $display("FAIL areset_run got run=%b beats=%0d want 0/0",
               RUNNING, BEATS);
    else pass_cnt++;
    LONG = 1'b0;
    tick();
    CLR = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    press_qd();
    repeat (45) tick();
    total_cnt++;
    if (beats4 !== 4'd15)
      $display("FAIL wrap_pre got %0d want 15", beats4);
    else pass_cnt++;
    repeat (3) tick();
    total_cnt++;
    if (beats4 !== 4'd0)
      $display("FAIL wrap_zero got %0d want 0", beats4);
    else pass_cnt++;
    total_cnt++;
    if (run4 !== 1'b1 || w4 !== 3'b001)
      $display("FAIL wrap_side got run=%b w=%b want 1/001", run4, w4);
    else pass_cnt++;
    total_cnt++;
    if (BEATS !== 16'd16)
      $display("FAIL wrap_wide got %0d want 16", BEATS);
    else pass_cnt++;
  endtask

  initial begin
    CLR = 1'b0;
    QD = 1'b0; DP = 1'b0;
    SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0;
    test_reset();
    test_start();
    test_long();
    test_short();
    test_stop();
    test_single_step();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
